// File: rtl/decompress_unpack_if.sv
// Stream-in / memory-write-out bundle for decompress_unpack.
interface decompress_unpack_if #(
  parameter int IN_W    = 64,
  parameter int COEFF_W = 24
);
  logic [IN_W-1:0]      data_i;
  logic                 data_valid_i;
  logic                 data_ready_o;
  logic                 mem_wr_valid;
  logic [4*COEFF_W-1:0] mem_wr_data;

  modport master (output data_i, data_valid_i,
                  input  data_ready_o, mem_wr_valid, mem_wr_data);
  modport slave  (input  data_i, data_valid_i,
                  output data_ready_o, mem_wr_valid, mem_wr_data);
endinterface

// File: rtl/decompress_unpack.sv
// ML-KEM Decompress_d unpacker: 64-bit LSB-first stream in, 4 coefficients per write out.
// Optional macro DECOMPRESS_D12_EN adds mode 5 (d=12 pass-through with range flag on err).
module decompress_unpack #(
  parameter int COEFF_W = 24,
  parameter int IN_W    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               zeroize,
  input  logic               decompress_enable,
  input  logic [2:0]         mode,
  input  logic [2:0]         num_poly,
  decompress_unpack_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state;
  logic [127:0]         bits_q;
  logic [7:0]           fill;
  logic [7:0]           words_in;
  logic [7:0]           in_words;
  logic [8:0]           wr_cnt;
  logic [8:0]           wr_total;
  logic [3:0]           d_q;
  logic                 vld_p1;
  logic [4*COEFF_W-1:0] data_p1;

  logic [3:0]           d_new;
  logic [5:0]           pop_w;
  logic                 start_ok;
  logic                 start_bad;
  logic                 accept;
  logic                 extract;
  logic                 last_wr;
  logic                 ext_err;
  logic [127:0]         shifted;
  logic [127:0]         bits_next;
  logic [7:0]           fill_after;
  logic [11:0]          x_lane [4];
  logic [4*COEFF_W-1:0] y_word;

  function automatic logic [3:0] d_of_mode(input logic [2:0] m);
    case (m)
      3'd0:    return 4'd1;
      3'd1:    return 4'd4;
      3'd2:    return 4'd5;
      3'd3:    return 4'd10;
      3'd4:    return 4'd11;
`ifdef DECOMPRESS_D12_EN
      3'd5:    return 4'd12;
`endif
      default: return 4'd0;
    endcase
  endfunction

  // Round-half-up of x*q/2^d; the 24-bit product never overflows for d <= 11.
  function automatic logic [11:0] decompress(input logic [11:0] x, input logic [3:0] d);
    logic [23:0] prod;
`ifdef DECOMPRESS_D12_EN
    if (d == 4'd12) return x;
`endif
    prod = 24'(x) * 24'd3329 + (24'd1 << (d - 4'd1));
    return 12'(prod >> d);
  endfunction

  function automatic logic [11:0] lane(input logic [127:0] b, input int unsigned k,
                                       input logic [3:0] d);
    logic [11:0] mask;
    mask = 12'((13'd1 << d) - 13'd1);
    return 12'(b >> (k * d)) & mask;
  endfunction

  assign d_new     = d_of_mode(mode);
  assign pop_w     = {d_q, 2'b00};
  assign start_ok  = (state == S_IDLE) && decompress_enable && (d_new != 4'd0) &&
                     (num_poly != 3'd0) && (num_poly <= 3'd4);
  assign start_bad = (state == S_IDLE) && decompress_enable && !start_ok;

  assign bus.data_ready_o = (state == S_RUN) && (fill <= 8'd64) && (words_in < in_words);
  assign accept  = bus.data_ready_o && bus.data_valid_i;
  assign extract = (state == S_RUN) && (fill >= {2'b00, pop_w}) && (wr_cnt < wr_total);
  assign last_wr = extract && (wr_cnt == wr_total - 9'd1);

  // New word lands just above whatever survives this cycle's pop.
  always_comb begin
    shifted    = extract ? (bits_q >> pop_w) : bits_q;
    fill_after = extract ? (fill - {2'b00, pop_w}) : fill;
    bits_next  = shifted;
    if (accept) bits_next = shifted | ({{(128-IN_W){1'b0}}, bus.data_i} << fill_after);
  end

  always_comb begin
    y_word = '0;
    for (int k = 0; k < 4; k++) begin
      x_lane[k] = lane(bits_q, k, d_q);
      y_word[k*COEFF_W +: COEFF_W] = COEFF_W'(decompress(x_lane[k], d_q));
    end
  end

`ifdef DECOMPRESS_D12_EN
  logic over;
  always_comb begin
    over = 1'b0;
    for (int k = 0; k < 4; k++)
      if ((d_q == 4'd12) && (x_lane[k] >= 12'd3329)) over = 1'b1;
  end
  assign ext_err = extract && over;
`else
  assign ext_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      state    <= S_IDLE;
      bits_q   <= '0;
      fill     <= '0;
      words_in <= '0;
      in_words <= '0;
      wr_cnt   <= '0;
      wr_total <= '0;
      d_q      <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // p0 -> p1: extracted lanes become the registered memory write
      vld_p1 <= extract;
      if (extract) data_p1 <= y_word;
      done <= 1'b0;
      err  <= start_bad || ext_err;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            d_q      <= d_new;
            in_words <= 8'(num_poly) * 8'({d_new, 2'b00});
            wr_total <= {num_poly, 6'd0};
            words_in <= '0;
            wr_cnt   <= '0;
            fill     <= '0;
            bits_q   <= '0;
          end
        end
        S_RUN: begin
          bits_q <= bits_next;
          fill   <= fill_after + (accept ? 8'd64 : 8'd0);
          if (accept)  words_in <= words_in + 8'd1;
          if (extract) wr_cnt   <= wr_cnt + 9'd1;
          if (last_wr) state    <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mem_wr_valid = vld_p1;
  assign bus.mem_wr_data  = data_p1;

endmodule

// File: tb/tb_decompress_unpack.sv
// Randomized bench for decompress_unpack with a bit-level reference model and scoreboard.
`timescale 1ns/1ps
module tb_decompress_unpack;
  localparam int CW   = 24;
  localparam int IN_W = 64;

  logic       clk = 1'b0;
  logic       reset, zeroize, decompress_enable;
  logic [2:0] mode, num_poly;
  logic       busy, done, err;

  decompress_unpack_if #(.IN_W(IN_W), .COEFF_W(CW)) bus ();

  decompress_unpack #(.COEFF_W(CW), .IN_W(IN_W)) dut (
    .clk(clk), .reset(reset), .zeroize(zeroize),
    .decompress_enable(decompress_enable), .mode(mode), .num_poly(num_poly),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int     checks = 0, errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4*CW-1:0] exp_q[$];
  bit              exp_err_q[$];
  logic [63:0]     words [192];
  int              n_words;
  int              job_exp_writes = 0, job_seen_writes = 0;
  int              done_seen = 0, done_base = 0, accepted = 0;
  longint          last_wr_cyc = 0;
  logic [4*CW-1:0] first_wr, mon_ew;
  bit              mon_ee;
  bit              allow_err = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: round(x*q/2^d) with ties upward, via integer division.
  function automatic int dref(input int d, input int x);
    if (d == 12) return x;
    return (2 * x * 3329 + (1 << d)) / (1 << (d + 1));
  endfunction

  task automatic gen_words(input int np, input int d, input int all_ones);
    n_words = np * 4 * d;
    for (int i = 0; i < n_words; i++)
      words[i] = all_ones ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
  endtask

  task automatic build_exp(input int np, input int d);
    logic [4*CW-1:0] v;
    bit e;
    int c, x, j;
    for (int w = 0; w < np * 64; w++) begin
      v = '0;
      e = 1'b0;
      for (int k = 0; k < 4; k++) begin
        c = w * 4 + k;
        x = 0;
        for (int b = 0; b < d; b++) begin
          j = c * d + b;
          x |= int'(words[j / 64][j % 64]) << b;
        end
        v[k*CW +: CW] = CW'(dref(d, x));
        if (d == 12 && x >= 3329) e = 1'b1;
      end
      exp_q.push_back(v);
      exp_err_q.push_back(e);
    end
    job_exp_writes = np * 64;
  endtask

  task automatic start(input int m, input int np);
    @(negedge clk);
    decompress_enable = 1'b1;
    mode = 3'(m);
    num_poly = 3'(np);
    job_seen_writes = 0;
    accepted = 0;
    done_base = done_seen;
    @(negedge clk);
    decompress_enable = 1'b0;
  endtask

  task automatic send_words(input int from, input int to, input int gap);
    int budget;
    for (int i = from; i < to; i++) begin
      while ($urandom_range(99) < gap) begin
        bus.data_valid_i = 1'b0;
        bus.data_i = {$urandom, $urandom};
        @(negedge clk);
      end
      bus.data_valid_i = 1'b1;
      bus.data_i = words[i];
      budget = 0;
      while (!bus.data_ready_o) begin
        @(negedge clk);
        budget++;
        if (budget > 500) begin
          $display("FAIL ready_timeout: word %0d never accepted", i);
          $fatal(1, "ready timeout");
        end
      end
      @(negedge clk);
      accepted++;
    end
    bus.data_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_seen == done_base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, done_seen - done_base, 1);
    chk({name, "_queue"}, exp_q.size(), 0);
  endtask

  task automatic bad_start(input int m, input int np, input string name);
    allow_err = 1'b1;
    @(negedge clk);
    decompress_enable = 1'b1;
    mode = 3'(m);
    num_poly = 3'(np);
    @(negedge clk);
    decompress_enable = 1'b0;
    chk({name, "_err"}, err, 1);
    chk({name, "_busy"}, busy, 0);
    @(negedge clk);
    chk({name, "_err_clear"}, err, 0);
    chk({name, "_idle"}, busy, 0);
    allow_err = 1'b0;
  endtask

  task automatic flush();
    exp_q.delete();
    exp_err_q.delete();
  endtask

  // Scoreboard: every write, err alignment and done latency.
  always @(negedge clk) begin
    if (bus.mem_wr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected none", bus.mem_wr_data);
      end else begin
        mon_ew = exp_q.pop_front();
        mon_ee = exp_err_q.pop_front();
        chk("wr_data", bus.mem_wr_data, mon_ew);
        chk("wr_err", err, mon_ee);
        chk("busy_on_write", busy, 1);
      end
      if (job_seen_writes == 0) first_wr = bus.mem_wr_data;
      job_seen_writes++;
      last_wr_cyc = cyc;
    end else if (!allow_err) begin
      chk("err_idle", err, 0);
    end
    if (done) begin
      chk("done_count", job_seen_writes, job_exp_writes);
      chk("done_latency", cyc - last_wr_cyc, 1);
      done_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, m;
    reset = 1'b1; zeroize = 1'b0; decompress_enable = 1'b0;
    mode = '0; num_poly = '0;
    bus.data_valid_i = 1'b0; bus.data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.mem_wr_valid, 0);
    chk("rst_data", bus.mem_wr_data, 0);
    chk("rst_ready", bus.data_ready_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;

    chk("ref_d1_x1", dref(1, 1), 1665);
    chk("ref_d4_x15", dref(4, 15), 3121);
    chk("ref_d4_x1", dref(4, 1), 208);
    chk("ref_d4_x8", dref(4, 8), 1665);
    chk("ref_d10_x1023", dref(10, 1023), 3326);
    chk("ref_d11_x1", dref(11, 1), 2);

    // T1: d=1, all ones
    gen_words(1, 1, 1);
    build_exp(1, 1);
    start(0, 1);
    send_words(0, 4, 0);
    chk("t1_ready_low", bus.data_ready_o, 0);
    chk("t1_busy", busy, 1);
    wait_done("t1_done");
    chk("t1_first", first_wr, {4{24'd1665}});
    chk("t1_words", accepted, 4);

    // T2: d=4 with known first nibbles; a start during RUN must be ignored
    gen_words(2, 4, 0);
    words[0][15:0] = 16'h801F;
    build_exp(2, 4);
    start(1, 2);
    decompress_enable = 1'b1; mode = 3'd6; num_poly = 3'd0;
    @(negedge clk);
    decompress_enable = 1'b0;
    send_words(0, 32, 20);
    wait_done("t2_done");
    chk("t2_first", first_wr, {24'd1665, 24'd0, 24'd208, 24'd3121});
    chk("t2_words", accepted, 32);

    // T3: d=10 and d=11 with gaps, then random jobs
    np = $urandom_range(1, 4);
    gen_words(np, 10, 0);
    words[0][9:0] = 10'h3FF;
    build_exp(np, 10);
    start(3, np);
    send_words(0, n_words, 40);
    wait_done("t3_d10_done");
    chk("t3_d10_first", first_wr[CW-1:0], 3326);

    np = $urandom_range(1, 4);
    gen_words(np, 11, 0);
    words[0][10:0] = 11'd1;
    build_exp(np, 11);
    start(4, np);
    send_words(0, n_words, 40);
    wait_done("t3_d11_done");
    chk("t3_d11_first", first_wr[CW-1:0], 2);

    for (int r = 0; r < 6; r++) begin
      m  = $urandom_range(0, 4);
      np = $urandom_range(1, 4);
      gen_words(np, (m == 0) ? 1 : (m == 1) ? 4 : (m == 2) ? 5 : (m == 3) ? 10 : 11, 0);
      build_exp(np, n_words / (np * 4));
      start(m, np);
      send_words(0, n_words, $urandom_range(0, 60));
      wait_done("t3_rand_done");
    end

    // T4: illegal starts
    bad_start(6, 1, "t4_mode6");
    bad_start(7, 2, "t4_mode7");
    bad_start(0, 0, "t4_np0");
    bad_start(1, 5, "t4_np5");
`ifndef DECOMPRESS_D12_EN
    bad_start(5, 1, "t4_mode5");
`endif

    // T5: reset mid-job, then a clean d=5 job
    gen_words(4, 5, 0);
    build_exp(4, 5);
    start(2, 4);
    send_words(0, 20, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_valid", bus.mem_wr_valid, 0);
    chk("t5_data", bus.mem_wr_data, 0);
    chk("t5_ready", bus.data_ready_o, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    flush();
    gen_words(4, 5, 0);
    build_exp(4, 5);
    start(2, 4);
    send_words(0, 80, 10);
    wait_done("t5_done_after");
    chk("t5_words", accepted, 80);

    // zeroize mid-job behaves like reset
    gen_words(2, 10, 0);
    build_exp(2, 10);
    start(3, 2);
    send_words(0, 10, 0);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    chk("zr_valid", bus.mem_wr_valid, 0);
    chk("zr_busy", busy, 0);
    chk("zr_ready", bus.data_ready_o, 0);
    flush();
    gen_words(1, 1, 0);
    build_exp(1, 1);
    start(0, 1);
    send_words(0, 4, 30);
    wait_done("zr_done_after");

`ifdef DECOMPRESS_D12_EN
    // T6: d=12 pass-through with out-of-range flag
    gen_words(1, 12, 0);
    words[0][11:0] = 12'hFFF;
    build_exp(1, 12);
    start(5, 1);
    send_words(0, 48, 20);
    wait_done("t6_done");
    chk("t6_first", first_wr[CW-1:0], 12'hFFF);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
